// File: rtl/mult_pipe_param_if.sv
// Operation/result bundle of the pipelined multiplier: issue side, result side,
// flush and the two ready signals.
interface mult_pipe_param_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned TAG_W = 4
);
  logic             flush;
  logic             start;
  logic             in_ready;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic             mcand_signed;
  logic             mplier_signed;
  logic             high_sel;
  logic [TAG_W-1:0] tag_in;
  logic [WIDTH-1:0] product;
  logic [TAG_W-1:0] tag_out;
  logic             done;
  logic             out_ready;

  modport master (
    output flush, start, mcand, mplier, mcand_signed, mplier_signed, high_sel, tag_in,
    output out_ready,
    input  in_ready, product, tag_out, done
  );

  modport slave (
    input  flush, start, mcand, mplier, mcand_signed, mplier_signed, high_sel, tag_in,
    input  out_ready,
    output in_ready, product, tag_out, done
  );
endinterface

// File: rtl/mult_pipe_param.sv
// STAGES-deep multiplier with per-stage bubble collapse: sign-magnitude operands,
// WIDTH/STAGES multiplier bits per level, negate + half select into the output level.
module mult_pipe_param #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 8,
  parameter int unsigned TAG_W  = 4
) (
  input logic              clock,
  input logic              reset,
  mult_pipe_param_if.slave bus
);
  localparam int unsigned SW   = WIDTH / STAGES;
  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned LAST = STAGES - 1;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [PW-1:0]    wide_t;

  // Levels 0..STAGES-2 carry operands; level STAGES-1 is the product/tag_out register.
  logic [STAGES-1:0] valid_q, valid_d, adv, load;
  word_t             mcand_q  [STAGES-1];
  word_t             mplier_q [STAGES-1];
  logic [TAG_W-1:0]  tag_q    [STAGES-1];
  wide_t             acc_q    [STAGES-1];
  wide_t             sum_c    [STAGES-1];
  logic [STAGES-2:0] neg_q, hi_q;
  wide_t             full_c, signed_c;
  word_t             product_d, product_q;
  logic [TAG_W-1:0]  tag_out_q;
  word_t             mcand_mag, mplier_mag;
  logic              neg_in;

  function automatic wide_t chunk_term(word_t a, word_t b, int k);
    wide_t ae, be;
    ae = {{WIDTH{1'b0}}, a};
    be = '0;
    be[SW-1:0] = b[k*SW +: SW];
    return (ae * be) << (k * SW);
  endfunction

  always_comb begin
    mcand_mag  = (bus.mcand_signed && bus.mcand[WIDTH-1]) ? -bus.mcand : bus.mcand;
    mplier_mag = (bus.mplier_signed && bus.mplier[WIDTH-1]) ? -bus.mplier : bus.mplier;
    neg_in     = (bus.mcand_signed & bus.mcand[WIDTH-1]) ^ (bus.mplier_signed & bus.mplier[WIDTH-1]);
  end

  // Ready ripples back from the consumer; a level moves if it is empty or its successor moves.
  always_comb begin
    logic chain;
    adv        = '0;
    chain      = !valid_q[LAST] || bus.out_ready;
    adv[LAST]  = chain;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      chain  = !valid_q[k] || chain;
      adv[k] = chain;
    end
  end

  always_comb begin
    load       = '0;
    valid_d    = valid_q;
    load[0]    = adv[0] && bus.start;
    valid_d[0] = adv[0] ? bus.start : valid_q[0];
    for (int k = 1; k < int'(STAGES); k++) begin
      load[k]    = adv[k] && valid_q[k-1];
      valid_d[k] = adv[k] ? valid_q[k-1] : valid_q[k];
    end
    if (bus.flush) valid_d = '0;
  end

  always_comb begin
    for (int k = 0; k < int'(STAGES) - 1; k++) begin
      sum_c[k] = acc_q[k] + chunk_term(mcand_q[k], mplier_q[k], k);
    end
    // The last operand level also folds in the top multiplier chunk.
    full_c    = sum_c[STAGES-2] + chunk_term(mcand_q[STAGES-2], mplier_q[STAGES-2], LAST);
    signed_c  = neg_q[STAGES-2] ? -full_c : full_c;
    product_d = hi_q[STAGES-2] ? signed_c[PW-1:WIDTH] : signed_c[WIDTH-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q   <= '0;
      neg_q     <= '0;
      hi_q      <= '0;
      product_q <= '0;
      tag_out_q <= '0;
      for (int k = 0; k < int'(STAGES) - 1; k++) begin
        mcand_q[k]  <= '0;
        mplier_q[k] <= '0;
        tag_q[k]    <= '0;
        acc_q[k]    <= '0;
      end
    end else begin
      valid_q <= valid_d;
      if (load[0]) begin
        mcand_q[0]  <= mcand_mag;
        mplier_q[0] <= mplier_mag;
        neg_q[0]    <= neg_in;
        hi_q[0]     <= bus.high_sel;
        tag_q[0]    <= bus.tag_in;
        acc_q[0]    <= '0;
      end
      for (int k = 1; k < int'(STAGES) - 1; k++) begin
        if (load[k]) begin
          mcand_q[k]  <= mcand_q[k-1];
          mplier_q[k] <= mplier_q[k-1];
          neg_q[k]    <= neg_q[k-1];
          hi_q[k]     <= hi_q[k-1];
          tag_q[k]    <= tag_q[k-1];
          acc_q[k]    <= sum_c[k-1];
        end
      end
      if (load[LAST]) begin
        product_q <= product_d;
        tag_out_q <= tag_q[STAGES-2];
      end
    end
  end

  assign bus.in_ready = adv[0];
  assign bus.done     = valid_q[LAST];
  assign bus.product  = product_q;
  assign bus.tag_out  = tag_out_q;
endmodule

// File: tb/tb_mult_pipe_param.sv
// Directed and randomised checks of mult_pipe_param at 64/8, 32/4 and 16/16 with a
// per-instance result scoreboard fed at accept time.
module tb_mult_pipe_param;
  typedef struct {
    logic [63:0] p;
    logic [3:0]  t;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exp_t q64[$];
  exp_t q32[$];
  exp_t q16[$];
  exp_t e64, e32, e16;

  mult_pipe_param_if #(.WIDTH(64), .TAG_W(4)) i64 ();
  mult_pipe_param_if #(.WIDTH(32), .TAG_W(4)) i32 ();
  mult_pipe_param_if #(.WIDTH(16), .TAG_W(4)) i16 ();

  mult_pipe_param #(.WIDTH(64), .STAGES(8), .TAG_W(4)) u64 (
    .clock(clock), .reset(reset), .bus(i64.slave));
  mult_pipe_param #(.WIDTH(32), .STAGES(4), .TAG_W(4)) u32 (
    .clock(clock), .reset(reset), .bus(i32.slave));
  mult_pipe_param #(.WIDTH(16), .STAGES(16), .TAG_W(4)) u16 (
    .clock(clock), .reset(reset), .bus(i16.slave));

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h required %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: extend both operands to 128 bits, multiply, pick the half.
  function automatic logic [63:0] ref_mul(logic [63:0] a, logic [63:0] b, int w,
                                          logic sa, logic sb, logic hi);
    logic [127:0] mask, ae, be, p;
    mask = (128'd1 << w) - 128'd1;
    ae   = {64'd0, a} & mask;
    be   = {64'd0, b} & mask;
    if (sa && ae[w-1]) ae = ae | ~mask;
    if (sb && be[w-1]) be = be | ~mask;
    p = ae * be;
    if (hi) p = p >> w;
    return p[63:0] & mask[63:0];
  endfunction

  function automatic logic [63:0] rnd(int w);
    logic [63:0] v, m;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = 64'd1 << (w - 1);
      default: v = {$urandom, $urandom};
    endcase
    return v & m;
  endfunction

  always @(negedge clock) begin
    if (reset && i64.done && i64.out_ready) begin
      if (q64.size() == 0) check("spurious64", {127'd0, i64.done}, 128'd0);
      else begin
        e64 = q64.pop_front();
        check("res64", {i64.product, i64.tag_out}, {e64.p, e64.t});
      end
    end
  end

  always @(negedge clock) begin
    if (reset && i32.done && i32.out_ready) begin
      if (q32.size() == 0) check("spurious32", {127'd0, i32.done}, 128'd0);
      else begin
        e32 = q32.pop_front();
        check("res32", {i32.product, i32.tag_out}, {e32.p[31:0], e32.t});
      end
    end
  end

  always @(negedge clock) begin
    if (reset && i16.done && i16.out_ready) begin
      if (q16.size() == 0) check("spurious16", {127'd0, i16.done}, 128'd0);
      else begin
        e16 = q16.pop_front();
        check("res16", {i16.product, i16.tag_out}, {e16.p[15:0], e16.t});
      end
    end
  end

  task automatic set64(input logic [63:0] a, input logic [63:0] b, input logic sa,
                       input logic sb, input logic hi, input logic [3:0] t);
    i64.mcand = a; i64.mplier = b; i64.mcand_signed = sa; i64.mplier_signed = sb;
    i64.high_sel = hi; i64.tag_in = t; i64.start = 1'b1;
  endtask

  task automatic issue64(input logic [63:0] a, input logic [63:0] b, input logic sa,
                         input logic sb, input logic hi, input logic [3:0] t,
                         input logic [63:0] exp);
    int n;
    set64(a, b, sa, sb, hi, t);
    n = 0;
    while (i64.in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (n == 40) check("ready_timeout", {127'd0, i64.in_ready}, 128'd1);
    q64.push_back('{exp, t});
    tick();
  endtask

  int lat, cnt, n_acc;
  logic [63:0] ra, rb;
  logic rsa, rsb, rhi;
  logic [3:0] rt;

  initial begin
    i64.flush = 0; i64.start = 0; i64.out_ready = 0; set64(0, 0, 0, 0, 0, 0); i64.start = 0;
    i32.flush = 0; i32.start = 0; i32.out_ready = 0; i32.mcand = 0; i32.mplier = 0;
    i32.mcand_signed = 0; i32.mplier_signed = 0; i32.high_sel = 0; i32.tag_in = 0;
    i16.flush = 0; i16.start = 0; i16.out_ready = 0; i16.mcand = 0; i16.mplier = 0;
    i16.mcand_signed = 0; i16.mplier_signed = 0; i16.high_sel = 0; i16.tag_in = 0;

    #2;
    check("rst_done", {127'd0, i64.done}, 128'd0);
    check("rst_product", {64'd0, i64.product}, 128'd0);
    check("rst_tag", {124'd0, i64.tag_out}, 128'd0);
    tick();
    reset = 1'b1;
    #1;
    check("rst_in_ready", {127'd0, i64.in_ready}, 128'd1);
    i64.out_ready = 1'b1;

    // Basic: 3*5, done in cycle STAGES counting the start cycle as 0, held one cycle.
    issue64(64'd3, 64'd5, 0, 0, 0, 4'd2, 64'd15);
    i64.start = 0;
    lat = 0;
    while (i64.done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", lat + 1, 128'd8);
    tick();
    check("done_once", {127'd0, i64.done}, 128'd0);

    // Signed modes and corners, back to back.
    issue64(64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 1, 1, 0, 4'd3, 64'hFFFF_FFFF_FFFF_FFFA);
    issue64(64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 1, 1, 1, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF);
    issue64(64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 0, 0, 1, 4'd5, 64'h0000_0000_0000_0002);
    issue64('1, '1, 0, 0, 1, 4'd6, 64'hFFFF_FFFF_FFFF_FFFE);
    issue64('1, '1, 0, 0, 0, 4'd7, 64'h1);
    issue64(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 1, 1, 4'd8,
            64'h4000_0000_0000_0000);
    issue64(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 1, 0, 4'd9, 64'h0);
    i64.start = 0;
    repeat (12) tick();
    check("drain_corners", q64.size(), 128'd0);

    // Backpressure: fill with out_ready low, then release.
    i64.out_ready = 0;
    n_acc = 0;
    while (i64.in_ready === 1'b1 && n_acc < 12) begin
      set64(64'(n_acc + 1), 64'(100 + n_acc), 0, 0, 0, 4'(n_acc));
      q64.push_back('{64'(n_acc + 1) * 64'(100 + n_acc), 4'(n_acc)});
      tick();
      n_acc++;
    end
    check("accepts", n_acc, 128'd8);
    check("full_in_ready", {127'd0, i64.in_ready}, 128'd0);
    set64(64'd9, 64'd108, 0, 0, 0, 4'd8);
    repeat (3) begin
      tick();
      check("stall_hold", {i64.product, i64.tag_out, i64.done}, {64'd100, 4'd0, 1'b1});
    end
    i64.out_ready = 1;
    #1;
    check("release_ready", {127'd0, i64.in_ready}, 128'd1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 2) begin
        set64(64'(9 + i), 64'(108 + i), 0, 0, 0, 4'(8 + i));
        q64.push_back('{64'(9 + i) * 64'(108 + i), 4'(8 + i)});
      end else begin
        i64.start = 0;
      end
      if (i64.done === 1'b1) cnt++;
      tick();
    end
    check("back_to_back", cnt, 128'd10);
    check("bp_done_low", {127'd0, i64.done}, 128'd0);

    // Bubbles: accepts in cycles 0 and 3, consumer stalled until cycle 20.
    i64.out_ready = 0;
    set64(64'd7, 64'd11, 0, 0, 0, 4'd10);
    q64.push_back('{64'd77, 4'd10});
    tick();
    i64.start = 0;
    tick(); tick();
    set64(64'd13, 64'd17, 0, 0, 0, 4'd11);
    q64.push_back('{64'd221, 4'd11});
    tick();
    i64.start = 0;
    repeat (15) tick();
    check("bubble_c19", {i64.done, i64.tag_out}, {1'b1, 4'd10});
    tick();
    i64.out_ready = 1;
    check("bubble_c20", {i64.done, i64.tag_out}, {1'b1, 4'd10});
    tick();
    check("bubble_c21", {i64.done, i64.tag_out}, {1'b1, 4'd11});
    tick();
    check("bubble_c22", {127'd0, i64.done}, 128'd0);

    // Flush: four in flight, flush with start held, nothing may come out.
    for (int i = 0; i < 4; i++) begin
      set64(64'(i + 2), 64'd3, 0, 0, 0, 4'd12);
      tick();
    end
    i64.flush = 1;
    tick();
    i64.flush = 0;
    i64.start = 0;
    check("flush_in_ready", {i64.in_ready, i64.done}, {1'b1, 1'b0});
    cnt = 0;
    repeat (12) begin
      if (i64.done !== 1'b0) cnt++;
      tick();
    end
    check("flush_no_done", cnt, 128'd0);

    // Asynchronous reset with a result waiting at the output.
    i64.out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      set64(64'(i + 5), 64'd7, 0, 0, 0, 4'd13);
      tick();
    end
    i64.start = 0;
    repeat (8) tick();
    check("pre_reset_done", {i64.done, i64.tag_out}, {1'b1, 4'd13});
    #3;
    reset = 0;
    #1;
    check("async_reset", {i64.done, i64.tag_out, i64.product}, {1'b0, 4'd0, 64'd0});
    tick(); tick();
    reset = 1;
    #1;
    check("post_reset_ready", {127'd0, i64.in_ready}, 128'd1);
    i64.out_ready = 1;
    cnt = 0;
    repeat (15) begin
      if (i64.done !== 1'b0) cnt++;
      tick();
    end
    check("no_stale", cnt, 128'd0);

    // Random sweep on all three instances with random stalls.
    for (int c = 0; c < 300; c++) begin
      i64.out_ready = ($urandom_range(0, 3) != 0);
      i32.out_ready = ($urandom_range(0, 3) != 0);
      i16.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      ra = rnd(64); rb = rnd(64); rsa = 1'($urandom_range(0, 1));
      rsb = 1'($urandom_range(0, 1)); rhi = 1'($urandom_range(0, 1)); rt = 4'($urandom);
      set64(ra, rb, rsa, rsb, rhi, rt);
      i64.start = 1'($urandom_range(0, 1));
      if (i64.start && i64.in_ready) q64.push_back('{ref_mul(ra, rb, 64, rsa, rsb, rhi), rt});

      ra = rnd(32); rb = rnd(32); rsa = 1'($urandom_range(0, 1));
      rsb = 1'($urandom_range(0, 1)); rhi = 1'($urandom_range(0, 1)); rt = 4'($urandom);
      i32.mcand = ra[31:0]; i32.mplier = rb[31:0]; i32.mcand_signed = rsa;
      i32.mplier_signed = rsb; i32.high_sel = rhi; i32.tag_in = rt;
      i32.start = 1'($urandom_range(0, 1));
      if (i32.start && i32.in_ready) q32.push_back('{ref_mul(ra, rb, 32, rsa, rsb, rhi), rt});

      ra = rnd(16); rb = rnd(16); rsa = 1'($urandom_range(0, 1));
      rsb = 1'($urandom_range(0, 1)); rhi = 1'($urandom_range(0, 1)); rt = 4'($urandom);
      i16.mcand = ra[15:0]; i16.mplier = rb[15:0]; i16.mcand_signed = rsa;
      i16.mplier_signed = rsb; i16.high_sel = rhi; i16.tag_in = rt;
      i16.start = 1'($urandom_range(0, 1));
      if (i16.start && i16.in_ready) q16.push_back('{ref_mul(ra, rb, 16, rsa, rsb, rhi), rt});
      tick();
    end
    i64.start = 0; i32.start = 0; i16.start = 0;
    i64.out_ready = 1; i32.out_ready = 1; i16.out_ready = 1;
    repeat (40) tick();
    check("drain64", q64.size(), 128'd0);
    check("drain32", q32.size(), 128'd0);
    check("drain16", q16.size(), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
